dtop_sweep_ctrl: RTL and testbench
==================================

// Module: dtop_sweep_ctrl
// PURPOSE
//  Sequencer for the combinational dtop datapath (37b scin, 8b cntrl -> 37b scout).
//  On start, holds a fixed scin and steps cntrl from cfg_first to cfg_last (mod 2^CNTRL_W).
//  At each step it waits a settle time, samples scout and emits {cntrl, scout} on a valid/ready result port.
//  Sits between dtop and the test/host logic; replaces free-running cntrl sweeps with a paced, back-pressured one.
// PARAMETERS
//  SC_W        37  width of dtop scin/scout
//  CNTRL_W     8   width of dtop cntrl
//  SETTLE_CYC  2   cycles from dt_cntrl update to scout sample; legal range 1..15
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        1-cycle request; sampled only in IDLE
//  abort       in   1        terminate sweep; return to IDLE
//  cfg_scin    in   SC_W     scin value held for the whole sweep (latched at start)
//  cfg_first   in   CNTRL_W  first cntrl code (latched at start)
//  cfg_last    in   CNTRL_W  last cntrl code, inclusive (latched at start)
//  dt_scin     out  SC_W     to dtop.scin
//  dt_cntrl    out  CNTRL_W  to dtop.cntrl
//  dt_scout    in   SC_W     from dtop.scout
//  res_valid   out  1        result available
//  res_ready   in   1        consumer accepts result
//  res_cntrl   out  CNTRL_W  cntrl code the result was sampled with
//  res_scout   out  SC_W     sampled scout
//  busy        out  1        high in any state except IDLE
//  done        out  1        1-cycle pulse after the last result is accepted
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; settle counter 0. All outputs are registered.
//  - FSM states: IDLE, SETTLE, PRESENT.
//  - IDLE: start=1 -> latch cfg_*; dt_scin<=cfg_scin, dt_cntrl<=cfg_first; load settle cnt=SETTLE_CYC; ->SETTLE.
//  - SETTLE: decrement cnt each cycle. At cnt==1: res_scout<=dt_scout, res_cntrl<=dt_cntrl, res_valid<=1; ->PRESENT.
//  - Latency: start at edge E0 -> dt_cntrl valid after E0+1; res_valid high after E0+1+SETTLE_CYC.
//  - PRESENT: res_valid/res_cntrl/res_scout held stable until res_valid&&res_ready.
//    On handshake: res_valid<=0. If dt_cntrl==cfg_last: done<=1 (one cycle), busy<=0, ->IDLE.
//    Otherwise: dt_cntrl<=dt_cntrl+1 (mod 2^CNTRL_W), reload cnt, ->SETTLE.
//  - Step count = ((cfg_last-cfg_first) mod 2^CNTRL_W)+1. first==last gives 1 step; 0..255 gives 256 steps.
//    first>last wraps through max code to 0 (e.g. 250..3 gives 10 steps).
//  - dt_scin changes only on start. dt_cntrl changes only on start or handshake; it holds its value in IDLE.
//  - start while busy: ignored.
//  - abort (any non-IDLE state, priority over handshake in the same cycle): res_valid<=0, ->IDLE, no done pulse.
//    dt_scin/dt_cntrl keep their values.
//  - start and abort together in IDLE: start wins (abort has no effect in IDLE).
//  - rst_n low mid-sweep: immediate return to reset values; no done pulse.
// STRUCTURE
//  - dtop_pkg holds: SC_W=37, CNTRL_W=8, state encoding (IDLE=2'd0, SETTLE=2'd1, PRESENT=2'd2).
//  - Sub-module dtop_settle_timer: loadable down-counter (load, tick, expire) parameterised by SETTLE_CYC.
//  - This block holds the FSM, config latches, cntrl stepper and result registers.
//  - dtop is instantiated beside it at the level above, not inside it.
// TESTING
//  - Bench instantiates dtop + dtop_sweep_ctrl and a reference scout model; SETTLE_CYC=2 unless noted.
//  1. Full sweep: scin=37'd91625968981, first=0, last=63, res_ready=1.
//     -> 64 results, res_cntrl 0..63 in order, each scout matches model; single done pulse; busy low after.
//  2. Back-pressure: first=5, last=7; res_ready low for 10 cycles on each result.
//     -> res_valid/res_cntrl/res_scout stable while stalled; exactly 3 results (5,6,7); dt_cntrl never skips.
//  3. Wrap and single step: first=254, last=1 -> results 254,255,0,1 then done.
//     first=last=9 -> exactly one result (9), then done.
//  4. Abort/start collisions: abort during SETTLE of step 3 of 0..63 -> res_valid 0 next cycle, IDLE, no done.
//     start pulses while busy -> ignored (cfg_first/cfg_last change unobserved).
//  5. Reset mid-sweep: rst_n low asynchronously while in PRESENT -> all outputs 0 before the next edge.
//     New start after release runs a clean sweep.
//  6. Latency: SETTLE_CYC=1 and SETTLE_CYC=4.
//     -> res_valid rises exactly 1+SETTLE_CYC edges after start, and SETTLE_CYC edges after each handshake.

Source files
------------

// File: rtl/dtop_pkg.sv
// dtop_pkg
//   Shared definitions for the dtop sweep controller slice: datapath widths
//   of the dtop block, the settle counter width and the sweep FSM encoding.
package dtop_pkg;

  // Width of the dtop scin/scout buses.
  localparam int SC_W    = 37;
  // Width of the dtop cntrl bus.
  localparam int CNTRL_W = 8;
  // Settle counter width; holds settle times 1..15.
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dtop_settle_timer.sv
// dtop_settle_timer
//   Loadable down-counter that paces how long dtop is given to settle after
//   a cntrl change before its scout is sampled.
// Ports
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset (count cleared to 0)
//   load    in  reload the count with SETTLE_CYC (wins over tick)
//   tick    in  decrement the count by one, saturating at 0
//   expire  out high while the count is 1, i.e. on the last settle cycle
module dtop_settle_timer
  import dtop_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Expiring at 1 rather than 0 lets the sample happen on the edge that
  // completes SETTLE_CYC cycles since the cntrl update.
  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/dtop_sweep_ctrl.sv
// dtop_sweep_ctrl
//   Paced, back-pressured sweep of the dtop cntrl code. On start it holds a
//   fixed scin, steps cntrl from cfg_first to cfg_last (wrapping modulo
//   2^CNTRL_W), waits SETTLE_CYC cycles at each step, samples scout and
//   offers {cntrl, scout} on a valid/ready result port.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin a sweep (IDLE only) / end it early
//   cfg_scin/first/last   sweep configuration, latched on start
//   dt_scin, dt_cntrl     drive dtop inputs
//   dt_scout              dtop output
//   res_valid/ready       result handshake
//   res_cntrl, res_scout  cntrl code and scout of the current result
//   busy                  high whenever a sweep is in progress
//   done                  one-cycle pulse when the last result is accepted
module dtop_sweep_ctrl
  import dtop_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SC_W-1:0]    cfg_scin,
  input  logic [CNTRL_W-1:0] cfg_first,
  input  logic [CNTRL_W-1:0] cfg_last,
  output logic [SC_W-1:0]    dt_scin,
  output logic [CNTRL_W-1:0] dt_cntrl,
  input  logic [SC_W-1:0]    dt_scout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNTRL_W-1:0] res_cntrl,
  output logic [SC_W-1:0]    res_scout,
  output logic               busy,
  output logic               done
);

  sweep_state_t state, state_nxt;

  logic [CNTRL_W-1:0] last_q;
  logic               tmr_load;
  logic               tmr_tick;
  logic               tmr_expire;
  logic               launch;
  logic               capture;
  logic               advance;
  logic               finish;

  dtop_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .tick  (tmr_tick),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort is checked before the handshake so an abort in the same cycle as
  // an accepted result neither advances cntrl nor produces a done pulse.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    launch    = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          tmr_tick = 1'b1;
          if (tmr_expire) begin
            capture   = 1'b1;
            state_nxt = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (res_valid && res_ready) begin
          if (dt_cntrl == last_q) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            tmr_load  = 1'b1;
            state_nxt = SETTLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only cfg_last needs its own latch: cfg_scin and cfg_first go straight
  // into the dtop drive registers, which hold them for the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_scin   <= '0;
      dt_cntrl  <= '0;
      last_q    <= '0;
      res_valid <= 1'b0;
      res_cntrl <= '0;
      res_scout <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (launch) begin
        dt_scin  <= cfg_scin;
        dt_cntrl <= cfg_first;
        last_q   <= cfg_last;
      end else if (advance) begin
        dt_cntrl <= dt_cntrl + 1'b1;
      end
      if (capture) begin
        res_cntrl <= dt_cntrl;
        res_scout <= dt_scout;
      end
      res_valid <= (state_nxt == PRESENT);
      busy      <= (state_nxt != IDLE);
      done      <= finish;
    end
  end

endmodule

// File: tb/tb_dtop_sweep_ctrl.sv
// tb_dtop_sweep_ctrl
//   Directed bench for dtop_sweep_ctrl. Three controllers (SETTLE_CYC 2, 1
//   and 4) share all inputs; each drives its own stand-in dtop built from
//   the reference scout model. The SETTLE_CYC=2 instance carries the
//   functional sweeps, the other two the latency checks.
module tb_dtop_sweep_ctrl;
  import dtop_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [SC_W-1:0]    cfg_scin;
  logic [CNTRL_W-1:0] cfg_first;
  logic [CNTRL_W-1:0] cfg_last;
  logic               res_ready;

  logic [SC_W-1:0]    dt_scin, dt_scout, res_scout;
  logic [CNTRL_W-1:0] dt_cntrl, res_cntrl;
  logic               res_valid, busy, done;

  logic [SC_W-1:0]    dt_scin1, dt_scout1, res_scout1;
  logic [CNTRL_W-1:0] dt_cntrl1, res_cntrl1;
  logic               res_valid1, busy1, done1;

  logic [SC_W-1:0]    dt_scin4, dt_scout4, res_scout4;
  logic [CNTRL_W-1:0] dt_cntrl4, res_cntrl4;
  logic               res_valid4, busy4, done4;

  int                 vectors = 0;
  int                 miscompares = 0;
  logic [SC_W-1:0]    exp_scin;

  always #5 clk = ~clk;

  // Reference scout model, also used as the combinational dtop stand-in.
  function automatic logic [SC_W-1:0] dtop_model(input logic [SC_W-1:0] s,
                                                 input logic [CNTRL_W-1:0] c);
    logic [SC_W-1:0] m;
    m = {c[4:0], c, c, c, c};
    return (s ^ m) + SC_W'(c);
  endfunction

  assign dt_scout  = dtop_model(dt_scin, dt_cntrl);
  assign dt_scout1 = dtop_model(dt_scin1, dt_cntrl1);
  assign dt_scout4 = dtop_model(dt_scin4, dt_cntrl4);

  dtop_sweep_ctrl #(.SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_scin(cfg_scin), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .dt_scin(dt_scin), .dt_cntrl(dt_cntrl), .dt_scout(dt_scout),
    .res_valid(res_valid), .res_ready(res_ready), .res_cntrl(res_cntrl),
    .res_scout(res_scout), .busy(busy), .done(done)
  );

  dtop_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_scin(cfg_scin), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .dt_scin(dt_scin1), .dt_cntrl(dt_cntrl1), .dt_scout(dt_scout1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_cntrl(res_cntrl1),
    .res_scout(res_scout1), .busy(busy1), .done(done1)
  );

  dtop_sweep_ctrl #(.SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_scin(cfg_scin), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .dt_scin(dt_scin4), .dt_cntrl(dt_cntrl4), .dt_scout(dt_scout4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_cntrl(res_cntrl4),
    .res_scout(res_scout4), .busy(busy4), .done(done4)
  );

  // Advance to 1ns after the next rising edge: inputs are driven and
  // outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_output("wait_valid", 64'(res_valid), 64'd1);
  endtask

  task automatic apply_stimulus(input logic [SC_W-1:0] scin,
                                input logic [CNTRL_W-1:0] first,
                                input logic [CNTRL_W-1:0] last);
    cfg_scin  = scin;
    cfg_first = first;
    cfg_last  = last;
    exp_scin  = scin;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check_output("start_busy", 64'(busy), 64'd1);
    check_output("start_scin", 64'(dt_scin), 64'(scin));
    check_output("start_cntrl", 64'(dt_cntrl), 64'(first));
  endtask

  // Accept count results starting at code first, stalling each one for
  // stall cycles before accepting it.
  task automatic collect(input logic [CNTRL_W-1:0] first, input int count,
                         input int stall, input bit expect_done);
    logic [CNTRL_W-1:0] code;
    code = first;
    for (int i = 0; i < count; i++) begin
      wait_valid();
      check_output("res_cntrl", 64'(res_cntrl), 64'(code));
      check_output("res_scout", 64'(res_scout), 64'(dtop_model(exp_scin, code)));
      check_output("done_mid", 64'(done), 64'd0);
      for (int s = 0; s < stall; s++) begin
        tick();
        check_output("stall_valid", 64'(res_valid), 64'd1);
        check_output("stall_cntrl", 64'(res_cntrl), 64'(code));
        check_output("stall_scout", 64'(res_scout), 64'(dtop_model(exp_scin, code)));
        check_output("stall_dt_cntrl", 64'(dt_cntrl), 64'(code));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_output("valid_after_hs", 64'(res_valid), 64'd0);
      code = code + 1'b1;
    end
    if (expect_done) begin
      check_output("done_pulse", 64'(done), 64'd1);
      check_output("busy_end", 64'(busy), 64'd0);
      tick();
      check_output("done_clear", 64'(done), 64'd0);
      check_output("valid_idle", 64'(res_valid), 64'd0);
    end
  endtask

  logic [11:0] lat_v1, lat_d1, lat_v2, lat_d2, lat_v4, lat_d4;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_scin  = '0;
    cfg_first = '0;
    cfg_last  = '0;
    res_ready = 1'b0;
    exp_scin  = '0;

    // Reset values.
    tick();
    tick();
    check_output("rst_valid", 64'(res_valid), 64'd0);
    check_output("rst_cntrl", 64'(res_cntrl), 64'd0);
    check_output("rst_scout", 64'(res_scout), 64'd0);
    check_output("rst_dt_scin", 64'(dt_scin), 64'd0);
    check_output("rst_dt_cntrl", 64'(dt_cntrl), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_valid1", 64'(res_valid1), 64'd0);
    check_output("rst_valid4", 64'(res_valid4), 64'd0);
    rst_n = 1'b1;
    tick();

    // Latency for SETTLE_CYC 1, 2 and 4 with res_ready held high on the
    // sweep 10..11. Bit k holds the value expected after edge k+1, where
    // edge 1 is the one that samples start.
    $display("[TB] latency");
    lat_v1 = 12'b0000_0000_1010;
    lat_d1 = 12'b0000_0001_0000;
    lat_v2 = 12'b0000_0010_0100;
    lat_d2 = 12'b0000_0100_0000;
    lat_v4 = 12'b0010_0001_0000;
    lat_d4 = 12'b0100_0000_0000;
    cfg_scin  = 37'h12_3456_789A;
    cfg_first = 8'd10;
    cfg_last  = 8'd11;
    res_ready = 1'b1;
    start     = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      start = 1'b0;
      check_output("lat_valid1", 64'(res_valid1), 64'(lat_v1[k]));
      check_output("lat_done1", 64'(done1), 64'(lat_d1[k]));
      check_output("lat_valid2", 64'(res_valid), 64'(lat_v2[k]));
      check_output("lat_done2", 64'(done), 64'(lat_d2[k]));
      check_output("lat_valid4", 64'(res_valid4), 64'(lat_v4[k]));
      check_output("lat_done4", 64'(done4), 64'(lat_d4[k]));
    end
    res_ready = 1'b0;
    tick();

    // Full sweep 0..63.
    $display("[TB] full sweep");
    apply_stimulus(37'd91625968981, 8'd0, 8'd63);
    collect(8'd0, 64, 0, 1'b1);

    // Back-pressure on 5..7.
    $display("[TB] back-pressure");
    apply_stimulus(37'h1F_0F0F_0F0F, 8'd5, 8'd7);
    collect(8'd5, 3, 10, 1'b1);

    // Wrap through the top code, then a single-step sweep.
    $display("[TB] wrap and single step");
    apply_stimulus(37'h0A_AAAA_5555, 8'd254, 8'd1);
    collect(8'd254, 4, 0, 1'b1);
    apply_stimulus(37'h00_0000_0001, 8'd9, 8'd9);
    collect(8'd9, 1, 0, 1'b1);

    // Abort during the settle of the third step of 0..63.
    $display("[TB] abort");
    apply_stimulus(37'h15_5555_AAAA, 8'd0, 8'd63);
    collect(8'd0, 2, 0, 1'b0);
    check_output("pre_abort_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_valid", 64'(res_valid), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_dt_cntrl", 64'(dt_cntrl), 64'd2);
    check_output("abort_dt_scin", 64'(dt_scin), 64'(37'h15_5555_AAAA));
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("post_abort_valid", 64'(res_valid), 64'd0);
      check_output("post_abort_done", 64'(done), 64'd0);
    end

    // Start pulses while busy are ignored.
    $display("[TB] start while busy");
    apply_stimulus(37'h03_0303_0303, 8'd20, 8'd22);
    cfg_first = 8'd100;
    cfg_last  = 8'd100;
    cfg_scin  = 37'h1F_FFFF_FFFF;
    start     = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    check_output("busy_start_scin", 64'(dt_scin), 64'(37'h03_0303_0303));
    collect(8'd20, 3, 0, 1'b1);

    // Start and abort together in IDLE: start wins.
    $display("[TB] start with abort in idle");
    cfg_scin  = 37'h07_7777_0000;
    cfg_first = 8'd40;
    cfg_last  = 8'd41;
    exp_scin  = 37'h07_7777_0000;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_output("sa_busy", 64'(busy), 64'd1);
    check_output("sa_dt_cntrl", 64'(dt_cntrl), 64'd40);
    collect(8'd40, 2, 0, 1'b1);

    // Asynchronous reset while a result is presented.
    $display("[TB] reset mid-sweep");
    apply_stimulus(37'h11_2233_4455, 8'd0, 8'd63);
    wait_valid();
    #3 rst_n = 1'b0;
    #1;
    check_output("arst_valid", 64'(res_valid), 64'd0);
    check_output("arst_cntrl", 64'(res_cntrl), 64'd0);
    check_output("arst_scout", 64'(res_scout), 64'd0);
    check_output("arst_dt_scin", 64'(dt_scin), 64'd0);
    check_output("arst_dt_cntrl", 64'(dt_cntrl), 64'd0);
    check_output("arst_busy", 64'(busy), 64'd0);
    check_output("arst_done", 64'(done), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(37'h0C_0FFE_E123, 8'd3, 8'd5);
    collect(8'd3, 3, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
